// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/memory/writeback,
// drives datapath enables, counts retired instructions and traps on illegal opcodes.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_operation,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRead = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StImmExec = 4'd10,
    StImmWb   = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        case (opcode)
          OpRType:               state_d = StRExec;
          OpLw, OpSw:            state_d = StMemAddr;
          OpBeq, OpBne:          state_d = StBranch;
          OpJ:                   state_d = StJump;
          OpAddi, OpAndi, OpOri: state_d = StImmExec;
          default:               state_d = StTrap;
        endcase
      end
      StMemAddr: state_d = (opcode == OpSw) ? StMemWr : StMemRead;
      StMemRead: state_d = mem_ready ? StMemWb : StMemRead;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
      StRExec:   state_d = StRWb;
      StRWb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StImmExec: state_d = StImmWb;
      StImmWb:   state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StFetch;
    endcase
  end

  // TRAP never leaves and unused-state recovery is excluded, so only states 1..11 can retire.
  always_comb begin
    retire  = (state_q != StFetch) && (state_q < StTrap) && (state_d == StFetch);
    count_d = retire ? count_q + 1'b1 : count_q;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_operation = 3'b000;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      StDecode:  alu_src_b = 2'b11;
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      StMemRead: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StRExec: begin
        alu_src_a     = 1'b1;
        alu_operation = 3'b010;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_operation = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (opcode == OpBne);
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StImmExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OpAddi:  alu_operation = 3'b100;
          OpAndi:  alu_operation = 3'b101;
          OpOri:   alu_operation = 3'b111;
          default: alu_operation = 3'b000;
        endcase
      end
      StImmWb:   reg_write = 1'b1;
      default:   ;
    endcase
    // Reset suppresses every side-effecting strobe in the same cycle it is asserted.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
    end
  end

  assign state       = state_q;
  assign illegal     = (state_q == StTrap);
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: per-cycle state/control/count vectors
// plus hand-written latency sequences.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]  pc_source, alu_src_b;
  logic [2:0]  alu_operation;
  logic [3:0]  state;
  logic [31:0] instr_count;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_operation(alu_operation),
    .state(state), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  exp_state;
    logic [18:0] exp_ctrl;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [18:0] act_ctrl;
  assign act_ctrl = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_operation, illegal};

  function automatic logic [18:0] cw(int pw, int pwc, int bne, int psrc, int iord, int mr,
                                     int mw, int irw, int rd, int m2r, int rw, int asa,
                                     int asb, int aop, int ill);
    return {pw[0], pwc[0], bne[0], psrc[1:0], iord[0], mr[0], mw[0], irw[0], rd[0], m2r[0],
            rw[0], asa[0], asb[1:0], aop[2:0], ill[0]};
  endfunction

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] c, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp_state = st; v.exp_ctrl = c; v.exp_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [18:0] c_rst, c_f1, c_f0, c_dec, c_madr, c_mrd, c_mwb, c_mwr, c_mwr_rst, c_rex, c_rwb;
  logic [18:0] c_bne, c_beq, c_jmp, c_ori, c_addi, c_andi, c_iwb, c_trap;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, J = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, BAD = 6'b111111;

  initial begin
    int n;
    c_rst     = cw(0,0,0,0,0,0,0,0,0,0,0,0,1,0,0);
    c_f1      = cw(1,0,0,0,0,1,0,1,0,0,0,0,1,0,0);
    c_f0      = cw(0,0,0,0,0,1,0,0,0,0,0,0,1,0,0);
    c_dec     = cw(0,0,0,0,0,0,0,0,0,0,0,0,3,0,0);
    c_madr    = cw(0,0,0,0,0,0,0,0,0,0,0,1,2,0,0);
    c_mrd     = cw(0,0,0,0,1,1,0,0,0,0,0,0,0,0,0);
    c_mwb     = cw(0,0,0,0,0,0,0,0,0,1,1,0,0,0,0);
    c_mwr     = cw(0,0,0,0,1,0,1,0,0,0,0,0,0,0,0);
    c_mwr_rst = cw(0,0,0,0,1,0,0,0,0,0,0,0,0,0,0);
    c_rex     = cw(0,0,0,0,0,0,0,0,0,0,0,1,0,2,0);
    c_rwb     = cw(0,0,0,0,0,0,0,0,1,0,1,0,0,0,0);
    c_bne     = cw(0,1,1,1,0,0,0,0,0,0,0,1,0,1,0);
    c_beq     = cw(0,1,0,1,0,0,0,0,0,0,0,1,0,1,0);
    c_jmp     = cw(1,0,0,2,0,0,0,0,0,0,0,0,0,0,0);
    c_ori     = cw(0,0,0,0,0,0,0,0,0,0,0,1,2,7,0);
    c_addi    = cw(0,0,0,0,0,0,0,0,0,0,0,1,2,4,0);
    c_andi    = cw(0,0,0,0,0,0,0,0,0,0,0,1,2,5,0);
    c_iwb     = cw(0,0,0,0,0,0,0,0,0,0,1,0,0,0,0);
    c_trap    = cw(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    // Reset held two cycles, then add.
    add(1, R, 1, 0, c_rst, 0);   add(1, R, 1, 0, c_rst, 0);
    add(0, R, 1, 0, c_f1, 0);    add(0, R, 1, 1, c_dec, 0);
    add(0, R, 1, 6, c_rex, 0);   add(0, R, 1, 7, c_rwb, 0);
    // lw with two FETCH stalls and one MEM_READ stall.
    add(0, LW, 0, 0, c_f0, 1);   add(0, LW, 0, 0, c_f0, 1);
    add(0, LW, 1, 0, c_f1, 1);   add(0, LW, 1, 1, c_dec, 1);
    add(0, LW, 1, 2, c_madr, 1); add(0, LW, 0, 3, c_mrd, 1);
    add(0, LW, 1, 3, c_mrd, 1);  add(0, LW, 1, 4, c_mwb, 1);
    // bne, beq.
    add(0, BNE, 1, 0, c_f1, 2);  add(0, BNE, 1, 1, c_dec, 2);  add(0, BNE, 1, 8, c_bne, 2);
    add(0, BEQ, 1, 0, c_f1, 3);  add(0, BEQ, 1, 1, c_dec, 3);  add(0, BEQ, 1, 8, c_beq, 3);
    // ori, addi, j, andi.
    add(0, ORI, 1, 0, c_f1, 4);  add(0, ORI, 1, 1, c_dec, 4);
    add(0, ORI, 1, 10, c_ori, 4); add(0, ORI, 1, 11, c_iwb, 4);
    add(0, ADDI, 1, 0, c_f1, 5); add(0, ADDI, 1, 1, c_dec, 5);
    add(0, ADDI, 1, 10, c_addi, 5); add(0, ADDI, 1, 11, c_iwb, 5);
    add(0, J, 1, 0, c_f1, 6);    add(0, J, 1, 1, c_dec, 6);    add(0, J, 1, 9, c_jmp, 6);
    add(0, ANDI, 1, 0, c_f1, 7); add(0, ANDI, 1, 1, c_dec, 7);
    add(0, ANDI, 1, 10, c_andi, 7); add(0, ANDI, 1, 11, c_iwb, 7);
    // sw zero-wait.
    add(0, SW, 1, 0, c_f1, 8);   add(0, SW, 1, 1, c_dec, 8);
    add(0, SW, 1, 2, c_madr, 8); add(0, SW, 1, 5, c_mwr, 8);
    // Illegal opcode: trap is absorbing and the count freezes.
    add(0, BAD, 1, 0, c_f1, 9);  add(0, BAD, 1, 1, c_dec, 9);
    for (int i = 0; i < 10; i++) add(0, BAD, 1, 12, c_trap, 9);
    add(1, BAD, 1, 12, c_trap, 9);
    // Reset mid-MEM_WRITE with memory stalled.
    add(0, SW, 1, 0, c_f1, 0);   add(0, SW, 1, 1, c_dec, 0);
    add(0, SW, 1, 2, c_madr, 0); add(0, SW, 0, 5, c_mwr, 0);
    add(1, SW, 0, 5, c_mwr_rst, 0);
    add(0, R, 1, 0, c_f1, 0);

    reset = 1'b1; opcode = R; mem_ready = 1'b1;
    tick();
    foreach (vecs[i]) begin
      reset = vecs[i].rst; opcode = vecs[i].op; mem_ready = vecs[i].rdy;
      #2;
      check($sformatf("v%0d state", i), {28'd0, state}, {28'd0, vecs[i].exp_state});
      check($sformatf("v%0d ctrl", i), {13'd0, act_ctrl}, {13'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d count", i), instr_count, vecs[i].exp_cnt);
      tick();
    end

    // Zero-wait latency: lw 5 cycles, then sw 4 cycles, each bounded.
    reset = 1'b1; tick(); reset = 1'b0;
    mem_ready = 1'b1; opcode = LW;
    n = 1; tick();
    while (state != 4'd0 && n < 20) begin tick(); n++; end
    check("lw latency", n, 5);
    check("lw retire", instr_count, 1);
    opcode = SW;
    n = 1; tick();
    while (state != 4'd0 && n < 20) begin tick(); n++; end
    check("sw latency", n, 4);
    check("sw retire", instr_count, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
